rsa_keygen: RTL and testbench
=============================

RSA_KEYGEN -- requirements
Module: rsa_keygen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bit width of primes p and q; key outputs are 2*WIDTH bits.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port KeyGenStart  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL have ports p, q  input  WIDTH  primes, sampled on the accepted KeyGenStart edge.
REQ-006 SHALL have port n  output  2*WIDTH  modulus p*q.
REQ-007 SHALL have port e  output  2*WIDTH  public exponent.
REQ-008 SHALL have port d  output  2*WIDTH  private exponent, e*d mod phi = 1.
REQ-009 SHALL have ports busy, done, err  output  1 each  busy level / one-cycle completion pulse / failure flag.

Function
REQ-010 SHALL implement states IDLE, LOAD, EGCD, CHECK, DONE.
REQ-011 IDLE with KeyGenStart=1 SHALL register p,q and go to LOAD; busy rises the next cycle and stays high until DONE exits.
REQ-012 LOAD (1 cycle) SHALL compute n=p*q, phi=(p-1)*(q-1), set candidate e=3, init r0=phi, r1=e, t0=0, t1=1 (t signed, 2*WIDTH+2 bits).
REQ-013 EGCD SHALL perform exactly one extended-Euclid step per cycle: qt=r0/r1; (r0,r1)<=(r1,r0-qt*r1); (t0,t1)<=(t1,t0-qt*t1); go to CHECK when r1==0.
REQ-014 CHECK (1 cycle): if r0==1, d=t0 (plus phi if negative), go to DONE; else e+=2, reinit r0=phi, r1=e, t0=0, t1=1, return to EGCD.
REQ-015 If candidate e >= phi in LOAD or CHECK, SHALL go to DONE with err=1, e=0, d=0, n still valid.
REQ-016 DONE SHALL assert done for exactly one cycle, then return to IDLE; n/e/d/err held until the next accepted KeyGenStart.
REQ-017 KeyGenStart while busy SHALL be ignored; KeyGenStart held high in IDLE after DONE SHALL start a new run.
REQ-018 err SHALL clear on every accepted KeyGenStart.

Reset
REQ-019 rst_n low SHALL force IDLE and n=e=d=0, busy=done=err=0 immediately, including mid-EGCD; no partial result is retained.
REQ-020 First KeyGenStart SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-021 Macro RSA_KEYGEN_INPUT_CHECK_EN defined: in LOAD, p==q, p<3, q<3, or even p/q SHALL go straight to DONE with err=1, n=e=d=0.
REQ-022 Macro undefined: no input validation; any p,q proceed through REQ-012..REQ-015.

Structure
REQ-023 Package rsa_pkg SHALL hold the default WIDTH constant and the keygen state enumeration typedef.
REQ-024 The combinational Euclid step (REQ-013 arithmetic) SHALL be a sub-module rsa_egcd_step; the FSM and registers stay in rsa_keygen.

Verification
REQ-025 p=61,q=53 -> n=3233, e=7, d=1783, err=0, one done pulse.
REQ-026 p=3,q=11 -> n=33, e=3, d=7; p=5,q=7 -> n=35, e=5, d=5.
REQ-027 p=2,q=3 -> phi=2, err=1, n=6, e=0, d=0.
REQ-028 p=q=7: macro defined -> err=1, n=0; macro undefined -> n=49, e=5, d=29, err=0.
REQ-029 rst_n pulsed low mid-EGCD for p=61,q=53 -> all outputs 0 same cycle; a new KeyGenStart then gives REQ-025 results.
REQ-030 KeyGenStart toggled during busy with different p,q -> ignored, results match the originally sampled p,q.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key generator.
//   WIDTH_DEF  : default prime width; the key outputs are 2*WIDTH_DEF bits
//   kg_state_e : key generator FSM state encoding
package rsa_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EGCD  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } kg_state_e;
endpackage

// File: rtl/rsa_egcd_step.sv
// One combinational step of the extended Euclidean algorithm.
//   r0, r1       : current remainder pair (unsigned, W bits)
//   t0, t1       : current Bezout coefficient pair (signed, W+2 bits)
//   r0_nx..t1_nx : pair values after one quotient step
// The step is only meaningful while r1 != 0. A zero divisor produces a zero
// quotient, so no X values leave the block in simulation.
module rsa_egcd_step #(
  parameter int W = 16
) (
  input  logic        [W-1:0] r0,
  input  logic        [W-1:0] r1,
  input  logic signed [W+1:0] t0,
  input  logic signed [W+1:0] t1,
  output logic        [W-1:0] r0_nx,
  output logic        [W-1:0] r1_nx,
  output logic signed [W+1:0] t0_nx,
  output logic signed [W+1:0] t1_nx
);
  logic        [W-1:0] qt;
  logic signed [W+1:0] qt_s;

  always_comb begin
    qt    = (r1 == '0) ? '0 : r0 / r1;
    // Zero-extend the quotient before the signed multiply.
    qt_s  = $signed({2'b00, qt});
    r0_nx = r1;
    r1_nx = r0 - qt * r1;
    t0_nx = t1;
    t1_nx = t0 - qt_s * t1;
  end
endmodule

// File: rtl/rsa_keygen.sv
// Small RSA key generator: from the primes p and q it computes n = p*q,
// the smallest odd public exponent e >= 3 with gcd(e, phi) = 1, and
// d = e^-1 mod phi.
//   clk, rst_n   : clock, asynchronous active-low reset
//   KeyGenStart  : start request, accepted only in IDLE
//   p, q         : primes, captured on the accepted start
//   n, e, d      : modulus, public exponent, private exponent
//   busy / done  : run in progress / one-cycle completion pulse
//   err          : no valid key (held with the results)
// Optional macro RSA_KEYGEN_INPUT_CHECK_EN rejects p==q, p<3, q<3 and even
// inputs in LOAD with err=1 and n=e=d=0.
module rsa_keygen
  import rsa_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               KeyGenStart,
  input  logic [WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] n,
  output logic [2*WIDTH-1:0] e,
  output logic [2*WIDTH-1:0] d,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int W2 = 2 * WIDTH;
  localparam int TW = W2 + 2;

  kg_state_e            state_q, state_d;
  logic [WIDTH-1:0]     p_q, p_d, q_q, q_d;
  logic [W2-1:0]        phi_q, phi_d, cand_q, cand_d;
  logic [W2-1:0]        r0_q, r0_d, r1_q, r1_d;
  logic signed [TW-1:0] t0_q, t0_d, t1_q, t1_d;
  logic [W2-1:0]        n_q, n_d, e_q, e_d, d_q, d_d;
  logic                 err_q, err_d;

  logic [W2-1:0]        r0_nx, r1_nx, phi_calc;
  logic signed [TW-1:0] t0_nx, t1_nx;
  logic [W2:0]          cand_nx;

  rsa_egcd_step #(.W(W2)) u_step (
    .r0(r0_q), .r1(r1_q), .t0(t0_q), .t1(t1_q),
    .r0_nx(r0_nx), .r1_nx(r1_nx), .t0_nx(t0_nx), .t1_nx(t1_nx)
  );

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    q_d      = q_q;
    phi_d    = phi_q;
    cand_d   = cand_q;
    r0_d     = r0_q;
    r1_d     = r1_q;
    t0_d     = t0_q;
    t1_d     = t1_q;
    n_d      = n_q;
    e_d      = e_q;
    d_d      = d_q;
    err_d    = err_q;
    phi_calc = (W2'(p_q) - W2'(1)) * (W2'(q_q) - W2'(1));
    // One extra bit so the next-candidate compare cannot wrap.
    cand_nx  = {1'b0, cand_q} + (W2 + 1)'(2);

    case (state_q)
      S_IDLE: if (KeyGenStart) begin
        p_d     = p;
        q_d     = q;
        err_d   = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        n_d    = W2'(p_q) * W2'(q_q);
        phi_d  = phi_calc;
        cand_d = W2'(3);
        r0_d   = phi_calc;
        r1_d   = W2'(3);
        t0_d   = '0;
        t1_d   = TW'(1);
`ifdef RSA_KEYGEN_INPUT_CHECK_EN
        if (p_q == q_q || p_q < WIDTH'(3) || q_q < WIDTH'(3) ||
            !p_q[0] || !q_q[0]) begin
          n_d     = '0;
          e_d     = '0;
          d_d     = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else
`endif
        if (W2'(3) >= phi_calc) begin
          e_d     = '0;
          d_d     = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_EGCD;
        end
      end
      S_EGCD: begin
        if (r1_q == '0) begin
          state_d = S_CHECK;
        end else begin
          r0_d = r0_nx;
          r1_d = r1_nx;
          t0_d = t0_nx;
          t1_d = t1_nx;
        end
      end
      S_CHECK: begin
        if (r0_q == W2'(1)) begin
          // t0 lies in (-phi, phi); fold negatives into [0, phi).
          e_d     = cand_q;
          d_d     = t0_q[TW-1] ? W2'(t0_q + $signed({2'b00, phi_q})) : W2'(t0_q);
          state_d = S_DONE;
        end else if (cand_nx >= {1'b0, phi_q}) begin
          e_d     = '0;
          d_d     = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cand_d  = cand_nx[W2-1:0];
          r0_d    = phi_q;
          r1_d    = cand_nx[W2-1:0];
          t0_d    = '0;
          t1_d    = TW'(1);
          state_d = S_EGCD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      q_q     <= '0;
      phi_q   <= '0;
      cand_q  <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      t0_q    <= '0;
      t1_q    <= '0;
      n_q     <= '0;
      e_q     <= '0;
      d_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      phi_q   <= phi_d;
      cand_q  <= cand_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      t0_q    <= t0_d;
      t1_q    <= t1_d;
      n_q     <= n_d;
      e_q     <= e_d;
      d_q     <= d_d;
      err_q   <= err_d;
    end
  end

  assign n    = n_q;
  assign e    = e_q;
  assign d    = d_q;
  assign err  = err_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
endmodule

// File: tb/tb_rsa_keygen.sv
module tb_rsa_keygen;
  localparam int WIDTH = 8;
  localparam int W2    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             KeyGenStart = 1'b0;
  logic [WIDTH-1:0] p = '0, q = '0;
  logic [W2-1:0]    n, e, d;
  logic             busy, done, err;

  typedef struct {
    logic [W2-1:0] n, e, d;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic done_prev = 1'b0;

  rsa_keygen #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .KeyGenStart(KeyGenStart), .p(p), .q(q),
    .n(n), .e(e), .d(d), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input int nn, input int ee, input int dd, input logic er);
    exp_t x;
    x.n = W2'(nn); x.e = W2'(ee); x.d = W2'(dd); x.err = er;
    return x;
  endfunction

  // Monitor: compares each completion pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_pulse_width", {31'b0, done_prev}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("n",   {16'b0, n}, {16'b0, x.n});
        chk("e",   {16'b0, e}, {16'b0, x.e});
        chk("d",   {16'b0, d}, {16'b0, x.d});
        chk("err", {31'b0, err}, {31'b0, x.err});
      end
    end
    done_prev <= done;
  end

  task automatic wait_done();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 3000) chk("timeout_done", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic run(input int pp, input int qq, input exp_t x);
    p = WIDTH'(pp);
    q = WIDTH'(qq);
    KeyGenStart = 1'b1;
    sb.push_back(x);
    @(negedge clk);
    KeyGenStart = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    wait_done();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_n"}, {16'b0, n}, 32'd0);
    chk({nm, "_e"}, {16'b0, e}, 32'd0);
    chk({nm, "_d"}, {16'b0, d}, 32'd0);
    chk({nm, "_flags"}, {29'b0, busy, done, err}, 32'd0);
  endtask

  initial begin
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // First start presented while the first rising edge with reset high comes.
    run(61, 53, mk(3233, 7, 1783, 1'b0));
    run(3, 11, mk(33, 3, 7, 1'b0));
    run(5, 7, mk(35, 5, 5, 1'b0));
    run(2, 3, mk(6, 0, 0, 1'b1));
    // Results and err held while idle.
    repeat (3) @(negedge clk);
    chk("hold_err", {31'b0, err}, 32'd1);
    chk("hold_n", {16'b0, n}, 32'd6);
`ifdef RSA_KEYGEN_INPUT_CHECK_EN
    run(7, 7, mk(0, 0, 0, 1'b1));
`else
    run(7, 7, mk(49, 5, 29, 1'b0));
`endif
    // err clears on accepted start.
    run(2, 3, mk(6, 0, 0, 1'b1));
    p = 8'd3; q = 8'd11; KeyGenStart = 1'b1;
    sb.push_back(mk(33, 3, 7, 1'b0));
    @(negedge clk);
    KeyGenStart = 1'b0;
    chk("err_clear_on_start", {31'b0, err}, 32'd0);
    wait_done();

    // Start pulses with other primes while busy are ignored.
    p = 8'd61; q = 8'd53; KeyGenStart = 1'b1;
    sb.push_back(mk(3233, 7, 1783, 1'b0));
    @(negedge clk);
    KeyGenStart = 1'b0;
    repeat (3) @(negedge clk);
    p = 8'd5; q = 8'd7; KeyGenStart = 1'b1;
    @(negedge clk);
    KeyGenStart = 1'b0;
    chk("busy_mid_run", {31'b0, busy}, 32'd1);
    wait_done();

    // Start held high through DONE launches a second run.
    p = 8'd5; q = 8'd7; KeyGenStart = 1'b1;
    sb.push_back(mk(35, 5, 5, 1'b0));
    sb.push_back(mk(35, 5, 5, 1'b0));
    for (int r = 0; r < 2; r++) begin
      int k;
      for (k = 0; k < 3000; k++) begin
        @(negedge clk);
        if (done) break;
      end
      if (k == 3000) chk("timeout_held", 32'd1, 32'd0);
    end
    KeyGenStart = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_queue_empty", sb.size(), 32'd0);
    chk("idle_after_held", {31'b0, busy}, 32'd0);

    // Reset mid-EGCD clears everything at once.
    p = 8'd61; q = 8'd53; KeyGenStart = 1'b1;
    @(negedge clk);
    KeyGenStart = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run(61, 53, mk(3233, 7, 1783, 1'b0));

    repeat (3) @(negedge clk);
    chk("final_queue_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
